// File: rtl/ias_exec_responder_if.sv
// rtl/ias_exec_responder_if.sv - command/response bundle between a sequencer and ias_exec_responder
interface ias_exec_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        opcode;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_error;
  logic [DATA_W-1:0] data_out;
  logic              carry;

  modport master (
    output cmd_valid, opcode, address, data_in, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_error, data_out, carry
  );

  modport slave (
    input  cmd_valid, opcode, address, data_in, rsp_ready,
    output cmd_ready, rsp_valid, rsp_error, data_out, carry
  );
endinterface

// File: rtl/ias_exec_responder.sv
// rtl/ias_exec_responder.sv - IAS instruction responder: accumulator, word memory, cmd/rsp handshake
// Define IAS_EXEC_SATURATE_EN to clamp ADD/SUB results instead of wrapping.
module ias_exec_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  ias_exec_responder_if.slave bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_DECODE     = 3'd1;
  localparam logic [2:0] S_EXECUTE    = 3'd2;
  localparam logic [2:0] S_WRITE_BACK = 3'd3;
  localparam logic [2:0] S_RESPOND    = 3'd4;

  localparam logic [7:0] OP_LOAD     = 8'd1;
  localparam logic [7:0] OP_STORE    = 8'd2;
  localparam logic [7:0] OP_ADD      = 8'd3;
  localparam logic [7:0] OP_SUB      = 8'd4;
  localparam logic [7:0] OP_CLEAR_AC = 8'd5;
  localparam logic [7:0] OP_STORE_AC = 8'd6;

  logic [2:0]        state;
  logic [7:0]        ir;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mbr;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] ac;
  logic              carry_q;
  logic              rsp_error_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              legal_op;
  logic [DATA_W:0]   add_sum;
  logic [DATA_W:0]   sub_diff;

  assign legal_op = (ir >= OP_LOAD) && (ir <= OP_STORE_AC);
  assign add_sum  = {1'b0, ac} + {1'b0, mdr};
  // Top bit of the widened difference is the borrow (mdr > ac).
  assign sub_diff = {1'b0, ac} - {1'b0, mdr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ir          <= '0;
      mar         <= '0;
      mbr         <= '0;
      ac          <= '0;
      carry_q     <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            ir          <= bus.opcode;
            mar         <= bus.address;
            mbr         <= bus.data_in;
            rsp_error_q <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (legal_op) begin
            state <= S_EXECUTE;
          end else begin
            rsp_error_q <= 1'b1;
            state       <= S_RESPOND;
          end
        end
        S_EXECUTE: state <= S_WRITE_BACK;
        S_WRITE_BACK: begin
          case (ir)
            OP_LOAD: ac <= mdr;
            OP_ADD: begin
              carry_q <= add_sum[DATA_W];
`ifdef IAS_EXEC_SATURATE_EN
              ac <= add_sum[DATA_W] ? {DATA_W{1'b1}} : add_sum[DATA_W-1:0];
`else
              ac <= add_sum[DATA_W-1:0];
`endif
            end
            OP_SUB: begin
              carry_q <= sub_diff[DATA_W];
`ifdef IAS_EXEC_SATURATE_EN
              ac <= sub_diff[DATA_W] ? '0 : sub_diff[DATA_W-1:0];
`else
              ac <= sub_diff[DATA_W-1:0];
`endif
            end
            OP_CLEAR_AC: begin
              ac      <= '0;
              carry_q <= 1'b0;
            end
            default: ;
          endcase
          state <= S_RESPOND;
        end
        S_RESPOND: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory is deliberately not reset; an async reset moves state off
  // WRITE_BACK so a dropped command never reaches the write below.
  always_ff @(posedge clk) begin
    if (state == S_EXECUTE) mdr <= mem[mar];
    if (state == S_WRITE_BACK) begin
      if (ir == OP_STORE)    mem[mar] <= mbr;
      if (ir == OP_STORE_AC) mem[mar] <= ac;
    end
  end

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.rsp_valid = (state == S_RESPOND);
  assign bus.rsp_error = rsp_error_q;
  assign bus.data_out  = ac;
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_ias_exec_responder.sv
// tb/tb_ias_exec_responder.sv - directed, model-checked bench for ias_exec_responder
module tb_ias_exec_responder;

`ifdef IAS_EXEC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ias_exec_responder_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  ias_exec_responder #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  int m_mem [256];
  int m_ac = 0;
  int m_carry = 0;
  int m_err = 0;
  bit pend_active = 1'b0;
  int p_op, p_a, p_d;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one whole instruction applied when its response appears.
  task automatic model_apply();
    int s;
    m_err = 0;
    case (p_op)
      1: m_ac = m_mem[p_a];
      2: m_mem[p_a] = p_d;
      3: begin
        s = m_ac + m_mem[p_a];
        m_carry = (s > 255) ? 1 : 0;
        m_ac = SAT ? ((s > 255) ? 255 : s) : (s % 256);
      end
      4: begin
        m_carry = (m_mem[p_a] > m_ac) ? 1 : 0;
        if (SAT) m_ac = m_carry ? 0 : m_ac - m_mem[p_a];
        else     m_ac = (m_ac - m_mem[p_a] + 256) % 256;
      end
      5: begin m_ac = 0; m_carry = 0; end
      6: m_mem[p_a] = m_ac;
      default: m_err = 1;
    endcase
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_ac = 0;
      m_carry = 0;
      pend_active = 1'b0;
    end else begin
      if (bus.rsp_valid && pend_active) begin
        model_apply();
        pend_active = 1'b0;
      end
      chk("data_out", int'(bus.data_out), m_ac);
      chk("carry", int'(bus.carry), m_carry);
      if (bus.rsp_valid) chk("rsp_error", int'(bus.rsp_error), m_err);
    end
  end

  task automatic drive_accept(input int op, input int a, input int d, input bit track);
    int w = 0;
    @(negedge clk);
    while (!bus.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_ready_wait", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.opcode    = 8'(op);
    bus.address   = 8'(a);
    bus.data_in   = 8'(d);
    @(posedge clk);
    #1;
    if (track) begin
      p_op = op; p_a = a; p_d = d;
      pend_active = 1'b1;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_ready_after_accept", int'(bus.cmd_ready), 0);
  endtask

  // Counts edges from the accept edge (edge 1) to the edge raising rsp_valid.
  task automatic wait_rsp(input int exp_lat);
    int n = 1;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rsp_latency", n, exp_lat);
    chk("rsp_valid", int'(bus.rsp_valid), 1);
  endtask

  task automatic issue(input int op, input int a, input int d);
    drive_accept(op, a, d, 1'b1);
    wait_rsp((op >= 1 && op <= 6) ? 4 : 2);
    @(posedge clk);
    #1;
    chk("back_to_idle", int'(bus.cmd_ready), 1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.opcode    = '0;
    bus.address   = '0;
    bus.data_in   = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", int'(bus.data_out), 0);
    chk("rst_carry", int'(bus.carry), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_error", int'(bus.rsp_error), 0);
    reset = 1'b0;
    #1;
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);

    issue(2, 1, 25);
    issue(2, 2, 50);
    issue(1, 1, 0);
    issue(3, 2, 0);
    chk("lit_add_75", int'(bus.data_out), 75);
    chk("lit_add_carry", int'(bus.carry), 0);
    issue(6, 3, 0);
    issue(5, 0, 0);
    issue(1, 3, 0);
    chk("lit_mem3_75", int'(bus.data_out), 75);

    issue(9, 3, 0);
    chk("lit_illegal_ac", int'(bus.data_out), 75);
    issue(1, 3, 0);
    chk("lit_mem3_after_illegal", int'(bus.data_out), 75);

    issue(2, 10, 200);
    issue(2, 11, 100);
    issue(1, 10, 0);
    issue(3, 11, 0);
    chk("lit_add_ovf", int'(bus.data_out), SAT ? 255 : 44);
    chk("lit_add_ovf_carry", int'(bus.carry), 1);

    issue(2, 12, 10);
    issue(2, 13, 30);
    issue(1, 12, 0);
    chk("lit_load_keeps_carry", int'(bus.carry), 1);
    issue(4, 13, 0);
    chk("lit_sub_borrow", int'(bus.data_out), SAT ? 0 : 236);
    chk("lit_sub_borrow_carry", int'(bus.carry), 1);
    issue(1, 13, 0);
    issue(4, 12, 0);
    chk("lit_sub_plain", int'(bus.data_out), 20);
    chk("lit_sub_plain_carry", int'(bus.carry), 0);

    // Response back-pressure with a second command waiting.
    bus.rsp_ready = 1'b0;
    drive_accept(1, 1, 0, 1'b1);
    wait_rsp(4);
    bus.cmd_valid = 1'b1;
    bus.opcode    = 8'd2;
    bus.address   = 8'd5;
    bus.data_in   = 8'd99;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("stall_rsp_valid", int'(bus.rsp_valid), 1);
      chk("stall_cmd_ready", int'(bus.cmd_ready), 0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_rsp_valid", int'(bus.rsp_valid), 0);
    chk("hs_cmd_ready", int'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    p_op = 2; p_a = 5; p_d = 99;
    pend_active = 1'b1;
    bus.cmd_valid = 1'b0;
    chk("pending_accepted", int'(bus.cmd_ready), 0);
    wait_rsp(4);
    @(posedge clk);
    #1;
    issue(1, 5, 0);
    chk("lit_mem5_99", int'(bus.data_out), 99);

    // Reset in EXECUTE of STORE_AC must drop the write.
    issue(2, 4, 7);
    chk("lit_ac_before_reset", int'(bus.data_out), 99);
    drive_accept(6, 4, 0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_data_out", int'(bus.data_out), 0);
    chk("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("mid_rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("mid_rst_carry", int'(bus.carry), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(1, 4, 0);
    chk("lit_mem4_kept", int'(bus.data_out), 7);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
